wb_arbiter_2m: RTL and testbench

Two-master WISHBONE arbiter for the ethernet subsystem. It shares one slave-side bus between two master ports, for example the MAC's RX/TX DMA masters toward a single memory slave. Ownership is granted per whole cycle (CYC high to CYC low), with round-robin fairness, so CAB and CTI bursts are never split. A response watchdog terminates a stalled access with ERR so the bus cannot lock.

---
 rtl/wb_arbiter_2m.sv | 125 ++++++++++++
 tb/tb_wb_arbiter_2m.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master WISHBONE arbiter: whole-cycle round-robin ownership of one slave
// bus, with a response watchdog that terminates stalled accesses with ERR.
module wb_arbiter_2m #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 4,
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  m0_CYC_I,
  input  logic                  m0_STB_I,
  input  logic                  m0_WE_I,
  input  logic                  m0_CAB_I,
  input  logic [ADDR_WIDTH-1:0] m0_ADR_I,
  input  logic [SEL_WIDTH-1:0]  m0_SEL_I,
  input  logic [DATA_WIDTH-1:0] m0_DAT_I,
  input  logic [TAG_WIDTH-1:0]  m0_TAG_I,
  output logic                  m0_ACK_O,
  output logic                  m0_ERR_O,
  output logic                  m0_RTY_O,
  output logic [DATA_WIDTH-1:0] m0_DAT_O,
  input  logic                  m1_CYC_I,
  input  logic                  m1_STB_I,
  input  logic                  m1_WE_I,
  input  logic                  m1_CAB_I,
  input  logic [ADDR_WIDTH-1:0] m1_ADR_I,
  input  logic [SEL_WIDTH-1:0]  m1_SEL_I,
  input  logic [DATA_WIDTH-1:0] m1_DAT_I,
  input  logic [TAG_WIDTH-1:0]  m1_TAG_I,
  output logic                  m1_ACK_O,
  output logic                  m1_ERR_O,
  output logic                  m1_RTY_O,
  output logic [DATA_WIDTH-1:0] m1_DAT_O,
  output logic                  s_CYC_O,
  output logic                  s_STB_O,
  output logic                  s_WE_O,
  output logic                  s_CAB_O,
  output logic [ADDR_WIDTH-1:0] s_ADR_O,
  output logic [SEL_WIDTH-1:0]  s_SEL_O,
  output logic [DATA_WIDTH-1:0] s_DAT_O,
  output logic [TAG_WIDTH-1:0]  s_TAG_O,
  input  logic                  s_ACK_I,
  input  logic                  s_ERR_I,
  input  logic                  s_RTY_I,
  input  logic [DATA_WIDTH-1:0] s_DAT_I,
  output logic [1:0]            gnt_o,
  output logic                  timeout_o
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_G0    = 2'b01;
  localparam logic [1:0] ST_G1    = 2'b10;
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
  localparam logic       WD_EN    = (TIMEOUT != 0);

  logic [1:0] r_gnt;
  logic [1:0] w_gnt_nxt;
  logic       r_last;
  logic [7:0] r_wd;
  logic       w_g0;
  logic       w_g1;
  logic       w_act;
  logic       w_term;
  logic       w_fire;

  // Next grant: hold for the whole cycle, hand over directly when the owner releases.
  always_comb begin
    w_gnt_nxt = r_gnt;
    case (r_gnt)
      ST_G0: if (!m0_CYC_I) w_gnt_nxt = m1_CYC_I ? ST_G1 : ST_IDLE;
      ST_G1: if (!m1_CYC_I) w_gnt_nxt = m0_CYC_I ? ST_G0 : ST_IDLE;
      default: begin
        if (m0_CYC_I && m1_CYC_I) w_gnt_nxt = r_last ? ST_G0 : ST_G1;
        else if (m0_CYC_I)        w_gnt_nxt = ST_G0;
        else if (m1_CYC_I)        w_gnt_nxt = ST_G1;
        else                      w_gnt_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_gnt  <= ST_IDLE;
      r_last <= 1'b1;
      r_wd   <= 8'd0;
    end else begin
      r_gnt <= w_gnt_nxt;
      if (w_gnt_nxt == ST_G0) r_last <= 1'b0;
      if (w_gnt_nxt == ST_G1) r_last <= 1'b1;
      if ((w_gnt_nxt != r_gnt) || w_fire || !w_act || w_term) r_wd <= 8'd0;
      else                                                    r_wd <= r_wd + 8'd1;
    end
  end

  assign w_g0   = (r_gnt == ST_G0);
  assign w_g1   = (r_gnt == ST_G1);
  assign w_term = s_ACK_I | s_ERR_I | s_RTY_I;
  assign w_act  = s_CYC_O & s_STB_O;
  // A slave termination in the limit cycle takes priority over the watchdog.
  assign w_fire = WD_EN & w_act & ~w_term & (r_wd == WD_LIMIT);

  assign s_CYC_O = ((m0_CYC_I & w_g0) | (m1_CYC_I & w_g1)) & ~RST_I;
  assign s_STB_O = ((m0_STB_I & w_g0) | (m1_STB_I & w_g1)) & ~RST_I;
  assign s_WE_O  = w_g1 ? m1_WE_I  : m0_WE_I;
  assign s_CAB_O = w_g1 ? m1_CAB_I : m0_CAB_I;
  assign s_ADR_O = w_g1 ? m1_ADR_I : m0_ADR_I;
  assign s_SEL_O = w_g1 ? m1_SEL_I : m0_SEL_I;
  assign s_DAT_O = w_g1 ? m1_DAT_I : m0_DAT_I;
  assign s_TAG_O = w_g1 ? m1_TAG_I : m0_TAG_I;

  assign m0_ACK_O = w_g0 & s_ACK_I & ~w_fire & ~RST_I;
  assign m0_ERR_O = w_g0 & (s_ERR_I | w_fire) & ~RST_I;
  assign m0_RTY_O = w_g0 & s_RTY_I & ~w_fire & ~RST_I;
  assign m1_ACK_O = w_g1 & s_ACK_I & ~w_fire & ~RST_I;
  assign m1_ERR_O = w_g1 & (s_ERR_I | w_fire) & ~RST_I;
  assign m1_RTY_O = w_g1 & s_RTY_I & ~w_fire & ~RST_I;
  assign m0_DAT_O = s_DAT_I;
  assign m1_DAT_O = s_DAT_I;

  assign gnt_o     = r_gnt;
  assign timeout_o = w_fire;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed vector bench for wb_arbiter_2m (DUT built with TIMEOUT = 5).
module tb_wb_arbiter_2m;

  localparam logic [31:0] A0 = 32'h1000_0040;
  localparam logic [31:0] A1 = 32'h2000_0080;
  localparam logic [31:0] D0 = 32'hD0D0_0000;
  localparam logic [31:0] D1 = 32'hD1D1_1111;
  localparam logic [3:0]  S0 = 4'hF;
  localparam logic [3:0]  S1 = 4'h3;
  localparam logic [4:0]  T1 = 5'b00011;
  localparam logic [4:0]  CTI_INC = 5'b01000;
  localparam logic [4:0]  CTI_END = 5'b11100;

  typedef struct {
    logic        rst;
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic        ack, err, rty;
    logic [31:0] sdat;
    logic [4:0]  tag0;
    logic [1:0]  e_gnt;
    logic        e_cyc, e_stb;
    logic [1:0]  e_ack, e_err, e_rty;
    logic        e_to;
    logic        e_src;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic m0_cyc, m0_stb, m1_cyc, m1_stb;
  logic [4:0]  m0_tag;
  logic m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic s_cyc, s_stb, s_we, s_cab;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic [4:0]  s_tag;
  logic s_ack, s_err, s_rty;
  logic [1:0]  gnt;
  logic timeout;

  int n_vec = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  wb_arbiter_2m #(.TIMEOUT(5)) dut (
    .CLK_I(clk), .RST_I(rst),
    .m0_CYC_I(m0_cyc), .m0_STB_I(m0_stb), .m0_WE_I(1'b0), .m0_CAB_I(1'b0),
    .m0_ADR_I(A0), .m0_SEL_I(S0), .m0_DAT_I(D0), .m0_TAG_I(m0_tag),
    .m0_ACK_O(m0_ack), .m0_ERR_O(m0_err), .m0_RTY_O(m0_rty), .m0_DAT_O(m0_dat_o),
    .m1_CYC_I(m1_cyc), .m1_STB_I(m1_stb), .m1_WE_I(1'b1), .m1_CAB_I(1'b1),
    .m1_ADR_I(A1), .m1_SEL_I(S1), .m1_DAT_I(D1), .m1_TAG_I(T1),
    .m1_ACK_O(m1_ack), .m1_ERR_O(m1_err), .m1_RTY_O(m1_rty), .m1_DAT_O(m1_dat_o),
    .s_CYC_O(s_cyc), .s_STB_O(s_stb), .s_WE_O(s_we), .s_CAB_O(s_cab),
    .s_ADR_O(s_adr), .s_SEL_O(s_sel), .s_DAT_O(s_dat_o), .s_TAG_O(s_tag),
    .s_ACK_I(s_ack), .s_ERR_I(s_err), .s_RTY_I(s_rty), .s_DAT_I(s_dat_i),
    .gnt_o(gnt), .timeout_o(timeout)
  );

  function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [1:0] s,
                              input logic a, input logic e, input logic y,
                              input logic [31:0] d, input logic [4:0] t,
                              input logic [1:0] eg, input logic ec, input logic es,
                              input logic [1:0] ea, input logic [1:0] ee, input logic [1:0] ey,
                              input logic eto, input logic esrc);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.ack = a; v.err = e; v.rty = y;
    v.sdat = d; v.tag0 = t; v.e_gnt = eg; v.e_cyc = ec; v.e_stb = es;
    v.e_ack = ea; v.e_err = ee; v.e_rty = ey; v.e_to = eto; v.e_src = esrc;
    return v;
  endfunction

  // One bus cycle: drive just after the rising edge, compare on the falling edge.
  task automatic run(input vec_t v, input string name);
    logic [10:0] act, exp;
    logic [74:0] ract, rexp;
    @(posedge clk); #1;
    rst = v.rst; m0_cyc = v.cyc[0]; m1_cyc = v.cyc[1]; m0_stb = v.stb[0]; m1_stb = v.stb[1];
    s_ack = v.ack; s_err = v.err; s_rty = v.rty; s_dat_i = v.sdat; m0_tag = v.tag0;
    @(negedge clk);
    n_vec++;
    act = {gnt, s_cyc, s_stb, m1_ack, m0_ack, m1_err, m0_err, m1_rty, m0_rty, timeout};
    exp = {v.e_gnt, v.e_cyc, v.e_stb, v.e_ack, v.e_err, v.e_rty, v.e_to};
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s ctrl {gnt,cyc,stb,ack,err,rty,to}: got %b want %b", name, act, exp);
    end
    ract = {s_adr, s_sel, s_tag, s_we, s_cab, s_dat_o};
    rexp = v.e_src ? {A1, S1, T1, 1'b1, 1'b1, D1} : {A0, S0, v.tag0, 1'b0, 1'b0, D0};
    if (ract !== rexp) begin
      n_bad++;
      $display("FAIL %s route {adr,sel,tag,we,cab,dat}: got %h want %h", name, ract, rexp);
    end
    if (m0_dat_o !== v.sdat || m1_dat_o !== v.sdat) begin
      n_bad++;
      $display("FAIL %s rdata: got %h/%h want %h", name, m0_dat_o, m1_dat_o, v.sdat);
    end
  endtask

  // Port monitor: terminations only to the owner, one at a time, legal grant encoding.
  always @(negedge clk) begin
    if (mon_en) begin
      n_vec++;
      if ((gnt == 2'b11) || (s_cyc && gnt == 2'b00) ||
          ((m0_ack | m0_err | m0_rty) && gnt != 2'b01) ||
          ((m1_ack | m1_err | m1_rty) && gnt != 2'b10) ||
          ($countones({m0_ack, m0_err, m0_rty}) > 1) ||
          ($countones({m1_ack, m1_err, m1_rty}) > 1)) begin
        n_bad++;
        $display("FAIL monitor: gnt=%b cyc=%b m0 a/e/r=%b%b%b m1 a/e/r=%b%b%b want legal",
                 gnt, s_cyc, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty);
      end
    end
  end

  initial begin
    rst = 1'b1; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    s_ack = 0; s_err = 0; s_rty = 0; s_dat_i = '0; m0_tag = '0;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;

    // Single master: four reads from m0.
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,         5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0, 32'h0,         5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 32'h1111_1111, 5'd0, 2'b01, 1, 1, 2'b01, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 32'h2222_2222, 5'd0, 2'b01, 1, 1, 2'b01, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 32'h3333_3333, 5'd0, 2'b01, 1, 1, 2'b01, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 32'h4444_4444, 5'd0, 2'b01, 1, 1, 2'b01, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0,         5'd0, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0,         5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    // Ties after reset: m0 first, then m1; slave ERR/RTY routing; m1 -> m0 handover.
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,         5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0, 32'h0,         5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 1, 0, 0, 32'hA5A5_A5A5, 5'd0, 2'b01, 1, 1, 2'b01, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0,         5'd0, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0, 32'h0,         5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 0, 1, 0, 32'h5A5A_5A5A, 5'd0, 2'b10, 1, 1, 2'b00, 2'b10, 2'b00, 0, 1));
    tbl.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0, 32'h0,         5'd0, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(0, 2'b01, 2'b01, 0, 0, 1, 32'hC3C3_C3C3, 5'd0, 2'b01, 1, 1, 2'b00, 2'b00, 2'b01, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0,         5'd0, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0,         5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Burst: m0 holds 8 CTI beats while m1 requests from beat 2.
    run(mk(0, 2'b01, 2'b01, 0, 0, 0, 32'h0, 5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "burst_req");
    for (int i = 0; i < 8; i++)
      run(mk(0, (i >= 1) ? 2'b11 : 2'b01, (i >= 1) ? 2'b11 : 2'b01, 1, 0, 0, 32'(i + 100),
             (i == 7) ? CTI_END : CTI_INC, 2'b01, 1, 1, 2'b01, 2'b00, 2'b00, 0, 0),
          $sformatf("burst_beat%0d", i));
    run(mk(0, 2'b10, 2'b10, 0, 0, 0, 32'h0,         5'd0, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "burst_gap");
    run(mk(0, 2'b10, 2'b10, 1, 0, 0, 32'hBEEF_0001, 5'd0, 2'b10, 1, 1, 2'b10, 2'b00, 2'b00, 0, 1), "burst_m1");
    run(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0,         5'd0, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1), "burst_end");
    run(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0,         5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "burst_idle");

    // Watchdog: ERR on 6th stalled STB cycle; later an ACK in the limit cycle wins.
    run(mk(0, 2'b01, 2'b01, 0, 0, 0, 32'h0, 5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "wd_req");
    for (int c = 1; c <= 12; c++)
      run(mk(0, 2'b01, 2'b01, (c == 12), 0, 0, 32'h0, 5'd0, 2'b01, 1, 1,
             (c == 12) ? 2'b01 : 2'b00, (c == 6) ? 2'b01 : 2'b00, 2'b00, (c == 6), 0),
          $sformatf("wd_c%0d", c));
    run(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0, 5'd0, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "wd_end");
    run(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0, 5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "wd_idle");

    // Reset during an active m1 strobe, then m1 regranted and timed out.
    run(mk(0, 2'b10, 2'b10, 0, 0, 0, 32'h0,         5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "rst_req");
    run(mk(0, 2'b10, 2'b10, 0, 0, 0, 32'h0,         5'd0, 2'b10, 1, 1, 2'b00, 2'b00, 2'b00, 0, 1), "rst_g1");
    run(mk(1, 2'b10, 2'b10, 1, 0, 0, 32'h7777_7777, 5'd0, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1), "rst_hit");
    run(mk(0, 2'b10, 2'b10, 0, 0, 0, 32'h0,         5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "rst_after");
    for (int c = 1; c <= 6; c++)
      run(mk(0, 2'b10, 2'b10, 0, 0, 0, 32'h0, 5'd0, 2'b10, 1, 1, 2'b00,
             (c == 6) ? 2'b10 : 2'b00, 2'b00, (c == 6), 1), $sformatf("rst_wd%0d", c));
    run(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0, 5'd0, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1), "rst_end");
    run(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0, 5'd0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "rst_idle");

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
